// File: rtl/keycode_rx_fifo.sv
// keycode_rx_fifo
//   Avalon-MM slave input port: hardware logic pushes words with in_valid,
//   the CPU pops them by reading the DATA register.
//   The block also provides status, sticky overflow, flush and a level
//   interrupt.
//
// Ports
//   clk, reset_n    system clock, asynchronous active-low reset
//   address         0 DATA (R, pop), 1 STATUS (R), 2 IRQ_EN (R/W), 3 CONTROL (W)
//   chipselect      slave select
//   read_n, write_n active-low strobes
//   writedata       CPU write data
//   readdata        combinational read data (zero wait states)
//   in_data         hardware word to push
//   in_valid        push strobe
//   irq             level interrupt: (en[0] & ~empty) | (en[1] & overflow)
module keycode_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            irq_en_q, irq_en_d;

    logic empty, full;
    logic pop, push_ok, ovf_evt;
    logic wr_irq_en, flush, clr_ovf;
    logic [31:0] head_ext;
    logic [31:0] status;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:2];

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // Bus decode
    assign pop       = chipselect & ~read_n & (address == 2'd0) & ~empty;
    assign wr_irq_en = chipselect & ~write_n & (address == 2'd2);
    assign flush     = chipselect & ~write_n & (address == 2'd3) & writedata[0];
    assign clr_ovf   = chipselect & ~write_n & (address == 2'd3) & writedata[1];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    // the word. Flush discards the push and suppresses the overflow event.
    assign push_ok = in_valid & (~full | pop) & ~flush;
    assign ovf_evt = in_valid & full & ~pop & ~flush;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        irq_en_d   = irq_en_q;
        // Set beats clear when both happen in the same cycle.
        overflow_d = ovf_evt | (overflow_q & ~clr_ovf);

        if (push_ok) begin
            mem_d[wr_ptr_q] = in_data;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end

        if (wr_irq_en) begin
            irq_en_d = writedata[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head_ext = '0;
        if (!empty) begin
            head_ext[DATA_WIDTH-1:0] = mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        status            = '0;
        status[0]         = empty;
        status[1]         = full;
        status[2]         = overflow_q;
        status[8 +: CNT_W] = count_q;
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = head_ext;
            2'd1:    readdata = status;
            2'd2:    readdata = {30'd0, irq_en_q};
            default: readdata = '0;
        endcase
    end

    assign irq = (irq_en_q[0] & ~empty) | (irq_en_q[1] & overflow_q);

endmodule

// File: tb/tb_keycode_rx_fifo.sv
module tb_keycode_rx_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of pending words plus flags
    logic [31:0] mq[$];
    bit          m_ovf;
    bit [1:0]    m_en;

    keycode_rx_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: if (mq.size() != 0) r = mq[0];
            2'd1: begin
                r[0]     = (mq.size() == 0);
                r[1]     = (mq.size() == DEPTH);
                r[2]     = m_ovf;
                r[15:8]  = 8'(mq.size());
            end
            2'd2: r[1:0] = m_en;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic model_irq();
        return (m_en[0] && mq.size() != 0) || (m_en[1] && m_ovf);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_en  = '0;
    endtask

    // Drive one bus/push cycle; returns the data seen mid-cycle and the
    // model's expectation, then advances the model across the clock edge.
    task automatic step(input bit rd, input bit wr, input logic [1:0] addr,
                        input logic [31:0] wdata, input bit v, input logic [31:0] d,
                        output logic [31:0] got, output logic [31:0] exp);
        bit ovf_evt, flush, clr;
        chipselect = rd | wr;
        read_n     = ~rd;
        write_n    = ~wr;
        address    = addr;
        writedata  = wdata;
        in_valid   = v;
        in_data    = d;
        #1;
        got = readdata;
        exp = model_read(addr);

        flush   = wr && addr == 2'd3 && wdata[0];
        clr     = wr && addr == 2'd3 && wdata[1];
        ovf_evt = 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (rd && addr == 2'd0 && mq.size() != 0) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else ovf_evt = 1;
            end
        end
        m_ovf = ovf_evt || (m_ovf && !clr);
        if (wr && addr == 2'd2) m_en = wdata[1:0];

        @(posedge clk);
        #1;
        chipselect = 0;
        read_n     = 1;
        write_n    = 1;
        in_valid   = 0;
        address    = 2'd0;
    endtask

    task automatic test_reset();
        logic [31:0] g, e;
        #1;
        n_checks++;
        if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp %h", readdata, 32'h0); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
        reset_n = 1;
        @(posedge clk); #1;
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got %h exp %h", g, 32'h1); end
    endtask

    task automatic test_order();
        logic [31:0] g, e;
        logic [31:0] words [3];
        words = '{32'h1C, 32'h32, 32'h23};
        for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 0, 1, words[i], g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0300) begin n_fail++; $display("FAIL order_status3 got %h exp %h", g, 32'h300); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 2'd0, 0, 0, 0, g, e);
            n_checks++;
            if (g !== words[i]) begin n_fail++; $display("FAIL order_data%0d got %h exp %h", i, g, words[i]); end
        end
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0001) begin n_fail++; $display("FAIL order_status0 got %h exp %h", g, 32'h1); end
        step(1, 0, 2'd0, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0) begin n_fail++; $display("FAIL order_empty_read got %h exp 0", g); end
    endtask

    task automatic test_overflow();
        logic [31:0] g, e;
        for (int i = 1; i <= 9; i++) step(0, 0, 2'd0, 0, 1, 32'(i), g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_status got %h exp %h", g, 32'h806); end
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 2'd0, 0, 0, 0, g, e);
            n_checks++;
            if (g !== 32'(i)) begin n_fail++; $display("FAIL ovf_data%0d got %h exp %h", i, g, 32'(i)); end
        end
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0005) begin n_fail++; $display("FAIL ovf_sticky got %h exp %h", g, 32'h5); end
        // Clear overflow while a new overflow event collides: set wins
        for (int i = 0; i < 8; i++) step(0, 0, 2'd0, 0, 1, 32'(i), g, e);
        step(0, 1, 2'd3, 32'h2, 1, 32'hEE, g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_set_wins got %h exp %h", g, 32'h806); end
        step(0, 1, 2'd3, 32'h3, 0, 0, g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_clear_flush got %h exp %h", g, 32'h1); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] g, e;
        for (int i = 0; i < 8; i++) step(0, 0, 2'd0, 0, 1, 32'h10 + 32'(i), g, e);
        step(1, 0, 2'd0, 0, 1, 32'hAA, g, e);
        n_checks++;
        if (g !== 32'h10) begin n_fail++; $display("FAIL fpp_head got %h exp %h", g, 32'h10); end
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0802) begin n_fail++; $display("FAIL fpp_status got %h exp %h", g, 32'h802); end
        for (int i = 1; i < 9; i++) begin
            step(1, 0, 2'd0, 0, 0, 0, g, e);
            n_checks++;
            if (g !== ((i == 8) ? 32'hAA : 32'h10 + 32'(i))) begin
                n_fail++; $display("FAIL fpp_drain%0d got %h exp %h", i, g, (i == 8) ? 32'hAA : 32'h10 + 32'(i));
            end
        end
        // Push and pop on an empty FIFO: pop suppressed, word kept
        step(1, 0, 2'd0, 0, 1, 32'h77, g, e);
        n_checks++;
        if (g !== 32'h0) begin n_fail++; $display("FAIL empty_pp_read got %h exp 0", g); end
        step(1, 0, 2'd0, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h77) begin n_fail++; $display("FAIL empty_pp_kept got %h exp %h", g, 32'h77); end
    endtask

    task automatic test_irq();
        logic [31:0] g, e;
        step(0, 1, 2'd2, 32'h1, 0, 0, g, e);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_empty got %b exp 0", irq); end
        step(0, 0, 2'd0, 0, 1, 32'h5A, g, e);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_nonempty got %b exp 1", irq); end
        step(1, 0, 2'd0, 0, 0, 0, g, e);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_pop got %b exp 0", irq); end
        step(0, 1, 2'd2, 32'hFFFF_FFFE, 0, 0, g, e);
        step(1, 0, 2'd2, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h2) begin n_fail++; $display("FAIL irq_en_read got %h exp %h", g, 32'h2); end
        for (int i = 0; i < 9; i++) step(0, 0, 2'd0, 0, 1, 32'(i), g, e);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_ovf got %b exp 1", irq); end
        step(0, 1, 2'd3, 32'h2, 0, 0, g, e);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ovf_clr got %b exp 0", irq); end
        step(0, 1, 2'd3, 32'h1, 0, 0, g, e);
        step(0, 1, 2'd2, 32'h0, 0, 0, g, e);
    endtask

    task automatic test_flush();
        logic [31:0] g, e;
        for (int i = 0; i < 5; i++) step(0, 0, 2'd0, 0, 1, 32'hC0 + 32'(i), g, e);
        step(0, 1, 2'd3, 32'h1, 1, 32'hDD, g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_status got %h exp %h", g, 32'h1); end
        step(1, 0, 2'd0, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0) begin n_fail++; $display("FAIL flush_data got %h exp 0", g); end
        // Flush on a full FIFO with push: no overflow, prior overflow kept
        for (int i = 0; i < 9; i++) step(0, 0, 2'd0, 0, 1, 32'(i), g, e);
        step(0, 1, 2'd3, 32'h1, 1, 32'hDD, g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0005) begin n_fail++; $display("FAIL flush_keep_ovf got %h exp %h", g, 32'h5); end
        // Write with no chipselect and CONTROL=0 are ignored
        for (int i = 0; i < 2; i++) step(0, 0, 2'd0, 0, 1, 32'h40 + 32'(i), g, e);
        chipselect = 0; write_n = 0; address = 2'd3; writedata = 32'h3;
        @(posedge clk); #1;
        write_n = 1;
        step(0, 1, 2'd3, 32'h0, 0, 0, g, e);
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0204) begin n_fail++; $display("FAIL nocs_ignored got %h exp %h", g, 32'h204); end
        step(0, 1, 2'd3, 32'h3, 0, 0, g, e);
    endtask

    task automatic test_reset_mid();
        logic [31:0] g, e;
        step(0, 1, 2'd2, 32'h1, 0, 0, g, e);
        for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 0, 1, 32'h90 + 32'(i), g, e);
        #2 reset_n = 0;
        model_reset();
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq got %b exp 0", irq); end
        @(posedge clk); #1;
        reset_n = 1;
        step(1, 0, 2'd1, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_mid_status got %h exp %h", g, 32'h1); end
        step(1, 0, 2'd2, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h0) begin n_fail++; $display("FAIL rst_mid_irqen got %h exp 0", g); end
        step(0, 0, 2'd0, 0, 1, 32'h55, g, e);
        step(1, 0, 2'd0, 0, 0, 0, g, e);
        n_checks++;
        if (g !== 32'h55) begin n_fail++; $display("FAIL rst_mid_push got %h exp %h", g, 32'h55); end
    endtask

    task automatic test_random();
        logic [31:0] g, e, wd;
        bit rd, wr, v;
        logic [1:0] a;
        for (int n = 0; n < 600; n++) begin
            rd = ($urandom_range(0, 3) == 0);
            wr = !rd && ($urandom_range(0, 7) == 0);
            a  = 2'($urandom_range(0, 3));
            if (rd && $urandom_range(0, 1) == 1) a = 2'd0;
            wd = $urandom;
            if (wr && a == 2'd3 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
            v  = ($urandom_range(0, 9) < 6);
            step(rd, wr, a, wd, v, $urandom, g, e);
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rand_read[%0d] addr %0d got %h exp %h", n, a, g, e); end
            n_checks++;
            if (irq !== model_irq()) begin n_fail++; $display("FAIL rand_irq[%0d] got %b exp %b", n, irq, model_irq()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_order();
        test_overflow();
        test_full_push_pop();
        test_irq();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
